wdt_kick_scheduler: RTL and testbench



---
 rtl/wdt_kick_scheduler.sv | 72 +++++++
 tb/tb_wdt_kick_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wdt_kick_scheduler.sv
// wdt_kick_scheduler: windowed heartbeat collector that reloads the watchdog only
// after every masked source checks in, and latches a fault on a premature round.
module wdt_kick_scheduler #(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1us,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic [NUM_SRC-1:0] hb,
  output logic               wdt_kick,
  output logic [31:0]        wdt_kick_value,
  output logic               fault
);
  typedef enum logic [1:0] {OFF, COLLECT, KICK, FAULT} state_t;
  state_t r_state, w_next;
  logic [31:0] r_reload, r_window, r_elapsed;
  logic r_en;
  logic [NUM_SRC-1:0] r_mask, r_pending, w_hb;
  logic w_ctrl_we, w_arm, w_done, w_unused;
  logic [31:0] w_ctrl, w_status;
  assign w_unused = &cfg_wdata;
  assign w_hb = hb & r_mask;
  // CTRL is only writable before the first accepted arm; afterwards it is locked
  assign w_ctrl_we = cfg_we && cfg_addr == 2'd2 && r_state == OFF;
  assign w_arm = w_ctrl_we && cfg_wdata[0] && |cfg_wdata[8 +: NUM_SRC] && |r_reload;
  assign w_done = ((r_pending | hb) & r_mask) == r_mask;
  always_comb begin
    w_next = r_state;
    case (r_state)
      OFF:     w_next = w_arm ? KICK : OFF;
      KICK:    w_next = COLLECT;
      COLLECT: w_next = !w_done ? COLLECT : (r_elapsed >= r_window) ? KICK : FAULT;
      default: w_next = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= OFF;
      r_reload  <= '0;
      r_window  <= '0;
      r_en      <= 1'b0;
      r_mask    <= '0;
      r_pending <= '0;
      r_elapsed <= '0;
    end else begin
      r_state <= w_next;
      if (cfg_we && cfg_addr == 2'd0) r_reload <= cfg_wdata;
      if (cfg_we && cfg_addr == 2'd1) r_window <= cfg_wdata;
      if (w_ctrl_we && (!cfg_wdata[0] || w_arm)) begin
        r_en   <= cfg_wdata[0];
        r_mask <= cfg_wdata[8 +: NUM_SRC];
      end
      // completion is judged on pre-increment elapsed; a new round starts from zero
      r_elapsed <= (w_next == KICK) ? '0 :
                   (tick_1us && r_elapsed != '1) ? r_elapsed + 32'd1 : r_elapsed;
      r_pending <= (r_state == KICK) ? w_hb :
                   (r_state == COLLECT) ? (r_pending | w_hb) : r_pending;
    end
  end
  assign wdt_kick       = r_state == KICK;
  assign wdt_kick_value = wdt_kick ? r_reload : '0;
  assign fault          = r_state == FAULT;
  assign w_ctrl   = (32'(r_mask) << 8) | 32'(r_en);
  assign w_status = 32'(r_pending) | (32'(r_state) << 16) | (32'(fault) << 24);
  assign cfg_rdata = cfg_addr == 2'd0 ? r_reload :
                     cfg_addr == 2'd1 ? r_window :
                     cfg_addr == 2'd2 ? w_ctrl : w_status;
endmodule

// File: tb/tb_wdt_kick_scheduler.sv
// tb_wdt_kick_scheduler: randomized and directed stimulus against a round-level
// reference model; predicted kicks are queued and checked by an independent monitor.
module tb_wdt_kick_scheduler;
  localparam int N = 4;
  logic clk = 0, rst = 1, tick_1us = 0, cfg_we = 0;
  logic [1:0] cfg_addr = 0;
  logic [31:0] cfg_wdata = 0, cfg_rdata, wdt_kick_value;
  logic [N-1:0] hb = 0;
  logic wdt_kick, fault;

  wdt_kick_scheduler #(.NUM_SRC(N)) dut (
    .clk(clk), .rst(rst), .tick_1us(tick_1us), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .hb(hb), .wdt_kick(wdt_kick),
    .wdt_kick_value(wdt_kick_value), .fault(fault)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] v; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  // round-level model: which sources have reported and how many ticks since the last kick
  bit m_armed, m_fault, m_kick;
  logic [31:0] m_reload, m_window, m_ticks, m_ctrl;
  logic [N-1:0] m_seen, m_mask;

  task automatic model(input bit r, input bit t, input logic [N-1:0] h, input bit we,
                       input logic [1:0] a, input logic [31:0] d);
    bit kick_next = 0;
    if (r) begin
      m_armed = 0; m_fault = 0; m_kick = 0; m_reload = 0; m_window = 0;
      m_ticks = 0; m_ctrl = 0; m_seen = 0;
      return;
    end
    m_mask = m_ctrl[8 +: N];
    if (m_kick) begin
      m_seen = h & m_mask;
      m_ticks = t ? 1 : 0;
    end else if (m_armed && !m_fault) begin
      if (((m_seen | h) & m_mask) == m_mask) begin
        if (m_ticks >= m_window) kick_next = 1;
        else m_fault = 1;
      end
      m_seen |= h & m_mask;
      if (t && m_ticks != 32'hFFFF_FFFF) m_ticks++;
    end else if (!m_armed && we && a == 2) begin
      if (!d[0]) m_ctrl = {16'b0, d[15:8] & 8'((1 << N) - 1), 8'b0};
      else if (d[8 +: N] != 0 && m_reload != 0) begin
        m_ctrl = {16'b0, d[15:8] & 8'((1 << N) - 1), 8'h01};
        m_armed = 1;
        kick_next = 1;
      end
    end
    if (we && a == 0) m_reload = d;
    if (we && a == 1) m_window = d;
    if (kick_next) q.push_back('{cyc + 1, m_reload});
    m_kick = kick_next;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit r, input bit t, input logic [N-1:0] h, input bit we,
                       input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; tick_1us = t; hb = h; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    model(r, t, h, we, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic ticks(input int n);
    repeat (n) drive(0, 1, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(0, 0, 0, 1, a, d);
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    drive(0, 0, 0, 0, a, 0);
    #1 chk(nm, cfg_rdata, exp);
  endtask
  task automatic rd_all_zero(input string nm);
    for (int i = 0; i < 4; i++) rd(2'(i), 0, $sformatf("%s_reg%0d", nm, i));
  endtask

  // kick monitor: every asserted wdt_kick must match the head of the expectation queue
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL missed_kick: kick absent at cycle %0d, expected value 0x%08h", q[0].c, q[0].v);
      void'(q.pop_front());
    end
    if (wdt_kick) begin
      n_chk++;
      if (q.size() == 0 || q[0].c != cyc || q[0].v !== wdt_kick_value) begin
        n_fail++;
        $display("FAIL kick: got value 0x%08h at cycle %0d, expected %s", wdt_kick_value, cyc,
                 q.size() == 0 ? "no kick" : $sformatf("0x%08h at cycle %0d", q[0].v, q[0].c));
      end
      if (q.size() > 0 && q[0].c == cyc) void'(q.pop_front());
    end
  end

  initial begin
    logic [N-1:0] h;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(1);
    chk("reset_kick", 32'(wdt_kick), 0);
    chk("reset_fault", 32'(fault), 0);
    rd_all_zero("reset");

    wr(0, 1000);
    wr(1, 0);
    wr(2, 32'h301);
    idle(2);
    rd(3, 32'h0001_0000, "arm_status_collect");
    wr(2, 0);
    rd(2, 32'h301, "lock_ctrl");

    wr(1, 20);
    ticks(5);
    drive(0, 0, 4'b0001, 0, 0, 0);
    ticks(45);
    drive(0, 0, 4'b0010, 0, 0, 0);
    idle(2);
    rd(3, 32'h0001_0000, "round_pending_cleared");
    drive(0, 0, 4'b0100, 0, 0, 0);
    idle(3);
    rd(3, 32'h0001_0000, "unmasked_hb_ignored");

    ticks(20);
    drive(0, 0, 4'b0011, 0, 0, 0);
    drive(0, 0, 4'b0001, 0, 0, 0);
    idle(1);
    rd(3, 32'h0001_0001, "hb_in_kick_cycle");

    ticks(20);
    drive(0, 0, 4'b0010, 0, 0, 0);
    idle(2);
    chk("exact_window_no_fault", 32'(fault), 0);
    rd(3, 32'h0001_0000, "exact_window_status");

    for (int i = 0; i < 3000; i++) begin
      h = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 60) == 0) drive(0, 1'($urandom), h, 1, 0, $urandom_range(0, 5000));
      else if ($urandom_range(0, 60) == 0) drive(0, 1'($urandom), h, 1, 1, $urandom_range(0, 15));
      else drive(0, 1'($urandom), h, 0, 0, 0);
    end
    idle(3);
    chk("random_fault_state", 32'(fault), 32'(m_fault));

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    wr(0, 7);
    wr(2, 32'h101);
    ticks(3);
    drive(1, 0, 0, 0, 0, 0);
    idle(1);
    chk("mid_reset_fault", 32'(fault), 0);
    rd_all_zero("mid_reset");

    wr(0, 500);
    wr(2, 1);
    idle(2);
    rd(3, 0, "mask0_stays_off");
    rd(2, 0, "mask0_ctrl_ignored");

    wr(1, 100);
    wr(2, 32'h301);
    idle(1);
    ticks(10);
    drive(0, 0, 4'b0011, 0, 0, 0);
    idle(1);
    chk("early_fault", 32'(fault), 1);
    drive(0, 0, 0, 0, 3, 0);
    #1 chk("fault_status", cfg_rdata >> 16, 32'h103);
    for (int i = 0; i < 10000; i++) drive(0, 1'($urandom), N'($urandom), 0, 0, 0);
    idle(2);
    chk("fault_sticky", 32'(fault), 1);
    chk("kick_queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
